// File: rtl/apb_master_pkg.sv
// Shared types and constants for the two-requester APB master.
package apb_master_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic SLV1 = 1'b0;
  localparam logic SLV2 = 1'b1;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;
endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter; the requester not served last wins a tie.
module apb_rr_arb2
  import apb_master_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);
  logic       last_q;
  logic [1:0] eff;

  always_comb begin
    eff   = req_i & ~mask_i;
    gnt_o = eff;
    if (eff == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
  end

  // Pointer starts at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  last_q <= 1'b1;
    else if (upd_i && |gnt_o)   last_q <= gnt_o[REQ1];
  end
endmodule

// File: rtl/apb_master_arb.sv
// Two-requester APB master with round-robin arbitration and slave decode.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_arb
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_write,
  input  logic [1:0][ADDR_W:0]   req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             req_done,
  output logic                   req_err,
  output logic [DATA_W-1:0]      req_rdata,
  output logic                   PSEL1,
  output logic                   PSEL2,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic                   PREADY1,
  input  logic                   PREADY2,
  input  logic [DATA_W-1:0]      PRDATA1,
  input  logic [DATA_W-1:0]      PRDATA2
);
  state_e              state_q;
  logic [1:0]          gnt_q, done_q;
  logic                slv_q, psel1_q, psel2_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q, rdata_q;

  logic [1:0]          mask, gnt;
  logic                gidx, rdy_sel, tmo, finish, launch;
  logic [DATA_W-1:0]   prdata_sel;

  // The finishing requester is masked so the other one can follow without an IDLE gap.
  assign mask       = (state_q == ST_ACCESS) ? gnt_q : 2'b00;
  assign gidx       = gnt[REQ1];
  assign rdy_sel    = (slv_q == SLV2) ? PREADY2 : PREADY1;
  assign prdata_sel = (slv_q == SLV2) ? PRDATA2 : PRDATA1;
  assign finish     = (state_q == ST_ACCESS) && (rdy_sel || tmo);
  assign launch     = (|gnt) && ((state_q == ST_IDLE) || finish);

  apb_rr_arb2 u_arb (
    .clk_i  (PCLK),
    .rst_i  (PRESET),
    .req_i  (req_valid),
    .mask_i (mask),
    .upd_i  (launch),
    .gnt_o  (gnt)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign tmo     = (state_q == ST_ACCESS) && !rdy_sel && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign req_err = err_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= finish && tmo;
      if (launch)                             cnt_q <= '0;
      else if (state_q == ST_ACCESS && !finish) cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign req_err = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      slv_q     <= 1'b0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
    end else begin
      done_q <= '0;
      if (state_q == ST_SETUP) begin
        penable_q <= 1'b1;
        state_q   <= ST_ACCESS;
      end
      if (finish) begin
        state_q   <= ST_IDLE;
        psel1_q   <= 1'b0;
        psel2_q   <= 1'b0;
        penable_q <= 1'b0;
        done_q    <= gnt_q;
        if (tmo)            rdata_q <= '1;
        else if (!pwrite_q) rdata_q <= prdata_sel;
      end
      // A new grant overrides the return to IDLE on a back-to-back completion.
      if (launch) begin
        state_q   <= ST_SETUP;
        gnt_q     <= gnt;
        slv_q     <= req_addr[gidx][ADDR_W];
        psel1_q   <= (req_addr[gidx][ADDR_W] == SLV1);
        psel2_q   <= (req_addr[gidx][ADDR_W] == SLV2);
        penable_q <= 1'b0;
        pwrite_q  <= req_write[gidx];
        paddr_q   <= req_addr[gidx][ADDR_W-1:0];
        pwdata_q  <= req_wdata[gidx];
      end
    end
  end

  assign req_done  = done_q;
  assign req_rdata = rdata_q;
  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb with two simple APB slave memories.
module tb_apb_master_arb;
  logic            PCLK, PRESET;
  logic [1:0]      req_valid, req_write, req_done;
  logic [1:0][8:0] req_addr;
  logic [1:0][7:0] req_wdata;
  logic            req_err;
  logic [7:0]      req_rdata, PADDR, PWDATA, PRDATA1, PRDATA2;
  logic            PSEL1, PSEL2, PENABLE, PWRITE, PREADY1, PREADY2;

  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  int total = 0;
  int bad   = 0;

  apb_master_arb dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done), .req_err(req_err),
    .req_rdata(req_rdata), .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY1(PREADY1),
    .PREADY2(PREADY2), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // slave2 powers up with mem2[a] = a ^ 8'h3C
  assign PRDATA1 = mem1[PADDR];
  assign PRDATA2 = mem2[PADDR];
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int a = 0; a < 256; a++) begin
        mem1[a] <= 8'h00;
        mem2[a] <= 8'(a) ^ 8'h3C;
      end
    end else begin
      if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR] <= PWDATA;
      if (PSEL2 && PENABLE && PREADY2 && PWRITE) mem2[PADDR] <= PWDATA;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_done(input int r, input int budget, input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!req_done[r] && n < budget);
    chk(tag, 32'(req_done[r]), 32'd1);
    req_valid[r] = 1'b0;
  endtask

  int n, en, dn;
  logic [7:0] rd;

  initial begin
    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PREADY1 = 1'b1; PREADY2 = 1'b1;
    tick(); tick();
    chk("rst_psel1", 32'(PSEL1), 0);
    chk("rst_psel2", 32'(PSEL2), 0);
    chk("rst_pen", 32'(PENABLE), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_err", 32'(req_err), 0);
    chk("rst_rdata", 32'(req_rdata), 0);
    chk("rst_paddr", 32'(PADDR), 0);
    PRESET = 1'b0;
    tick();

    // r0 write 9'h005 <- A5, zero-wait slave1
    req_addr[0] = 9'h005; req_wdata[0] = 8'hA5; req_write[0] = 1'b1; req_valid[0] = 1'b1;
    tick();
    chk("wr_c1_psel1", 32'(PSEL1), 1);
    chk("wr_c1_pen", 32'(PENABLE), 0);
    chk("wr_c1_paddr", 32'(PADDR), 32'h05);
    chk("wr_c1_pwrite", 32'(PWRITE), 1);
    chk("wr_c1_pwdata", 32'(PWDATA), 32'hA5);
    tick();
    chk("wr_c2_pen", 32'(PENABLE), 1);
    chk("wr_c2_done", 32'(req_done), 0);
    tick();
    chk("wr_c3_done", 32'(req_done), 32'b01);
    chk("wr_c3_psel1", 32'(PSEL1), 0);
    chk("wr_c3_pen", 32'(PENABLE), 0);
    req_valid[0] = 1'b0;
    chk("wr_mem1", 32'(mem1[8'h05]), 32'hA5);
    req_write[0] = 1'b0; req_valid[0] = 1'b1;
    wait_done(0, 20, "rd_done", n);
    chk("rd_lat", 32'(n), 3);
    chk("rd_data", 32'(req_rdata), 32'hA5);

    // r1 read slave2 9'h110
    req_addr[1] = 9'h110; req_write[1] = 1'b0; req_valid[1] = 1'b1;
    tick();
    chk("s2_psel2", 32'(PSEL2), 1);
    chk("s2_psel1", 32'(PSEL1), 0);
    chk("s2_paddr", 32'(PADDR), 32'h10);
    tick(); tick();
    chk("s2_done", 32'(req_done), 32'b10);
    chk("s2_rdata", 32'(req_rdata), 32'h2C);
    req_valid[1] = 1'b0;
    tick();
    chk("s2_idle", 32'(PSEL2), 0);

    // reset in the middle of an ACCESS phase
    req_addr[0] = 9'h007; req_wdata[0] = 8'h5A; req_write[0] = 1'b1; PREADY1 = 1'b0;
    req_valid[0] = 1'b1;
    tick(); tick();
    chk("mr_pen_before", 32'(PENABLE), 1);
    PRESET = 1'b1;
    #1;
    chk("mr_psel1", 32'(PSEL1), 0);
    chk("mr_pen", 32'(PENABLE), 0);
    req_valid[0] = 1'b0; PREADY1 = 1'b1;
    tick();
    chk("mr_done", 32'(req_done), 0);
    PRESET = 1'b0;
    tick();
    chk("mr_idle_psel1", 32'(PSEL1), 0);
    chk("mr_idle_done", 32'(req_done), 0);

    // both requesters held: r0 first, then strict alternation with no IDLE gap
    req_addr[0] = 9'h020; req_wdata[0] = 8'h11; req_write[0] = 1'b1;
    req_addr[1] = 9'h121; req_wdata[1] = 8'h22; req_write[1] = 1'b1;
    req_valid = 2'b11;
    tick();
    chk("rr_c1_psel1", 32'(PSEL1), 1);
    chk("rr_c1_paddr", 32'(PADDR), 32'h20);
    tick();
    tick();
    chk("rr_c3_done", 32'(req_done), 32'b01);
    chk("rr_c3_psel2", 32'(PSEL2), 1);
    chk("rr_c3_pen", 32'(PENABLE), 0);
    chk("rr_c3_paddr", 32'(PADDR), 32'h21);
    tick();
    chk("rr_c4_done", 32'(req_done), 0);
    tick();
    chk("rr_c5_done", 32'(req_done), 32'b10);
    chk("rr_c5_psel1", 32'(PSEL1), 1);
    tick(); tick();
    chk("rr_c7_done", 32'(req_done), 32'b01);
    chk("rr_c7_psel2", 32'(PSEL2), 1);
    req_valid = 2'b00;
    tick(); tick();
    chk("rr_c9_done", 32'(req_done), 32'b10);
    tick();
    chk("rr_c10_psel", 32'({PSEL1, PSEL2}), 0);
    chk("rr_mem1", 32'(mem1[8'h20]), 32'h11);
    chk("rr_mem2", 32'(mem2[8'h21]), 32'h22);

    // slave2 wait states; PREADY1 high must be ignored
    req_addr[1] = 9'h133; req_write[1] = 1'b0; PREADY2 = 1'b0; PREADY1 = 1'b1;
    req_valid[1] = 1'b1; en = 0; dn = 0; rd = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (PENABLE) en++;
      if (req_done[1]) begin
        dn++;
        rd = req_rdata;
        req_valid[1] = 1'b0;
      end
      if (k == 5) PREADY2 = 1'b1;
    end
    chk("ws_pen_cycles", 32'(en), 4);
    chk("ws_done_cnt", 32'(dn), 1);
    chk("ws_rdata", 32'(rd), 32'h0F);

    // stuck slave1
    req_addr[0] = 9'h044; req_write[0] = 1'b0; PREADY1 = 1'b0; req_valid[0] = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
    n = 0; en = 0;
    do begin
      tick();
      n++;
      if (PENABLE) en++;
    end while (!req_done[0] && n < 40);
    chk("to_done", 32'(req_done[0]), 1);
    chk("to_lat", 32'(n), 18);
    chk("to_pen_cycles", 32'(en), 16);
    chk("to_err", 32'(req_err), 1);
    chk("to_rdata", 32'(req_rdata), 32'hFF);
    req_valid[0] = 1'b0; PREADY1 = 1'b1;
    tick();
    chk("to_idle", 32'(PSEL1), 0);
    chk("to_err_clr", 32'(req_err), 0);
`else
    dn = 0;
    for (int k = 1; k <= 102; k++) begin
      tick();
      if (req_done[0]) dn++;
    end
    chk("st_no_done", 32'(dn), 0);
    chk("st_pen", 32'(PENABLE), 1);
    chk("st_psel1", 32'(PSEL1), 1);
    PREADY1 = 1'b1;
    wait_done(0, 5, "st_done", n);
    chk("st_lat", 32'(n), 1);
    chk("st_err", 32'(req_err), 0);
    chk("st_rdata", 32'(req_rdata), 32'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
